aes128_decrypt: RTL and testbench

Iterative AES-128 decryption core (FIPS-197 inverse cipher) that pairs with the team's AES-128 encryption datapath and recovers plaintext from a 128-bit ciphertext block. It takes the cipher key, expands it forward on chip to the round-10 key, then runs the inverse cipher while rolling the key schedule backwards, one round per clock. It sits between the ciphertext source and the plaintext consumer (display/LCD driver) in the top level, using a start/done handshake.

---
 rtl/aes_pkg.sv | 134 +++++++++++++
 rtl/aes128_key_step.sv | 27 ++
 rtl/aes128_decrypt.sv | 105 ++++++++++
 tb/tb_aes128_decrypt.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants, S-boxes and GF(2^8) helpers.
// The encryption datapath imports the same package.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_INIT,
    ST_ROUND,
    ST_FINAL
  } state_e;

  localparam logic [3:0] NR = 4'd10;

  // Rcon indexed by round number 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    // NOTE: every function/always_comb output gets a default so no path leaves it unassigned (no latch).
    case (rnd)
      4'd1: r = 8'h01;  4'd2: r = 8'h02;  4'd3: r = 8'h04;  4'd4: r = 8'h08;
      4'd5: r = 8'h10;  4'd6: r = 8'h20;  4'd7: r = 8'h40;  4'd8: r = 8'h80;
      4'd9: r = 8'h1b;  4'd10: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] s;
    case (a)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
            gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
            gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
            gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// Combinational AES-128 round-key step, forward (i_dir=0) or inverse (i_dir=1).
// Both directions share one 4-S-box SubWord; only its input word differs.
module aes128_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  input  logic         i_dir,
  output logic [127:0] o_key
);

  logic [31:0] w_k0, w_k1, w_k2, w_k3;
  logic [31:0] w_t3, w_rot, w_g;

  assign {w_k0, w_k1, w_k2, w_k3} = i_key;

  // Inverse direction recovers the previous w3 (= w7 ^ w6) before SubWord.
  assign w_t3  = i_dir ? (w_k3 ^ w_k2) : w_k3;
  assign w_rot = {w_t3[23:0], w_t3[31:24]};
  assign w_g   = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
               ^ {i_rcon, 24'h0};

  assign o_key = i_dir
    ? {w_k0 ^ w_g, w_k1 ^ w_k0, w_k2 ^ w_k1, w_k3 ^ w_k2}
    : {w_k0 ^ w_g, w_k1 ^ w_k0 ^ w_g, w_k2 ^ w_k1 ^ w_k0 ^ w_g, w_k3 ^ w_k2 ^ w_k1 ^ w_k0 ^ w_g};

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one
// decryption round per clock while the key schedule is rolled backwards.
module aes128_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  state_e       r_fsm;
  logic [3:0]   r_rnd;
  logic [127:0] r_key;
  logic [127:0] r_state;
  logic         r_busy;
  logic         r_done;
  logic [127:0] r_dout;

  logic [127:0] w_key_next;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  aes128_key_step u_key_step (
    .i_key  (r_key),
    .i_rcon (rcon(r_rnd)),
    .i_dir  (r_fsm != ST_KEYEXP),
    .o_key  (w_key_next)
  );

  // InvShiftRows folded into the S-box input selection: out[r][c] = in[r][(c-r) mod 4].
  for (genvar i = 0; i < 16; i++) begin : g_isb
    localparam int COL = i / 4;
    localparam int ROW = i % 4;
    localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
    assign w_isb[127-8*i -: 8] = inv_sbox(r_state[127-8*SRC -: 8]);
  end

  assign w_ark = w_isb ^ r_key;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign w_imc[127-32*c -: 32] = inv_mix_column(w_ark[127-32*c -: 32]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: key and state registers are cleared too, so no key material survives an aborted block.
      r_fsm   <= ST_IDLE;
      r_rnd   <= 4'd0;
      r_key   <= '0;
      r_state <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (start) begin
            r_key   <= key_in;
            r_state <= data_in;
            r_rnd   <= 4'd1;
            r_busy  <= 1'b1;
            r_fsm   <= ST_KEYEXP;
          end
        end
        ST_KEYEXP: begin
          r_key <= w_key_next;
          if (r_rnd == NR) r_fsm <= ST_INIT;
          else             r_rnd <= r_rnd + 4'd1;
        end
        ST_INIT: begin
          r_state <= r_state ^ r_key;
          r_key   <= w_key_next;
          r_rnd   <= NR - 4'd1;
          r_fsm   <= ST_ROUND;
        end
        ST_ROUND: begin
          r_state <= w_imc;
          r_key   <= w_key_next;
          r_rnd   <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) r_fsm <= ST_FINAL;
        end
        ST_FINAL: begin
          r_dout <= w_ark;
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_fsm  <= ST_IDLE;
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_dout;

endmodule

// File: tb/tb_aes128_decrypt.sv
// Scoreboard bench for aes128_decrypt: FIPS-197 vectors, abort/ignore cases and a
// random round trip through a behavioural AES-128 encryption model.
module tb_aes128_decrypt;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  aes128_decrypt dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural encryption model ----------------
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] tb_next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] tb_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] st;
    logic [7:0]   rc;
    rk = k;
    st = pt ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[c*4+w] = s[((c + w) % 4) * 4 + w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
          t[4*c+3] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
        end
      end
      rk = tb_next_key(rk, rc);
      rc = tb_xt(rc);
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
    end
    return st;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 128'(done), 128'd0);
      end else begin
        e = sb.pop_front();
        check("data_out", data_out, e.pt);
        check("latency", 128'(cyc - e.acc), 128'd21);
        check("busy_at_done", 128'(busy), 128'd0);
      end
    end
  end

  // Called on a negedge with the DUT idle; returns the acceptance cycle.
  task automatic launch(input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] pt, output int acc);
    key_in  = k;
    data_in = ct;
    start   = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back('{pt: pt, acc: acc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending", 128'(sb.size()), 128'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc0;
    logic [127:0] k, p, ct;

    reset   = 1'b1;
    start   = 1'b0;
    key_in  = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_data_out", data_out, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1
    launch(C1_KEY, C1_CT, C1_PT, acc);
    wait_drain(40);

    // FIPS-197 App. B with forward-expanded key peek after KEYEXP
    launch(B_KEY, B_CT, B_PT, acc);
    while (cyc < acc + 10) @(negedge clk);
    check("rk10_after_keyexp", dut.r_key, B_RK10);
    wait_drain(40);

    // Start pulses and input changes while busy are ignored
    launch(C1_KEY, C1_CT, C1_PT, acc);
    while (cyc < acc + 21) begin
      check("busy_continuous", 128'(busy), 128'd1);
      if (cyc < acc + 20) begin
        start   = 1'($urandom_range(0, 1));
        key_in  = {$urandom, $urandom, $urandom, $urandom};
        data_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain(40);
    repeat (25) @(negedge clk);

    // Reset mid-block discards the block
    launch(B_KEY, B_CT, B_PT, acc);
    while (cyc < acc + 15) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    check("abort_data_out", data_out, 128'd0);
    repeat (30) @(negedge clk);
    check("abort_idle_busy", 128'(busy), 128'd0);
    launch(B_KEY, B_CT, B_PT, acc);
    wait_drain(40);

    // Back-to-back: start held high through done
    key_in  = C1_KEY;
    data_in = C1_CT;
    start   = 1'b1;
    @(posedge clk);
    #1;
    acc0 = cyc;
    sb.push_back('{pt: C1_PT, acc: acc0});
    @(negedge clk);
    key_in  = B_KEY;
    data_in = B_CT;
    while (cyc < acc0 + 21) @(negedge clk);
    @(posedge clk);
    #1;
    sb.push_back('{pt: B_PT, acc: cyc});
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);

    // Random round trip through the encryption model
    for (int n = 0; n < 100; n++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      p  = {$urandom, $urandom, $urandom, $urandom};
      ct = tb_encrypt(k, p);
      launch(k, ct, p, acc);
      wait_drain(40);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
